snn_sched: RTL and testbench
============================

SNN_SCHED -- requirements
Module: snn_sched

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 98, giving the number of image bytes per frame (98 x 8 = 784 pixels).
REQ-002 SHALL have parameter ASCII_BASE, default 8'h30, added to the result digit for transmission.
REQ-003 SHALL have port clk  input  1  single system clock, all flops on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx_rdy  input  1  one-cycle strobe, byte valid on rx_data.
REQ-006 SHALL have port rx_data  input  8  received image byte, pixel order LSB first.
REQ-007 SHALL have port ram_we  output  1  write enable to input-unit RAM.
REQ-008 SHALL have port ram_addr  output  10  input-unit RAM address.
REQ-009 SHALL have port ram_d  output  1  pixel bit written to input-unit RAM.
REQ-010 SHALL have port core_addr  input  10  core's input-unit read address.
REQ-011 SHALL have port core_start  output  1  one-cycle start pulse to core.
REQ-012 SHALL have port core_done  input  1  core completion strobe.
REQ-013 SHALL have port core_digit  input  4  core result, valid when core_done=1.
REQ-014 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-015 SHALL have port tx_data  output  8  byte to transmit.
REQ-016 SHALL have port tx_done  input  1  transmitter completion strobe.
REQ-017 SHALL have port digit  output  4  last classified digit, held.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port overrun  output  1  sticky flag, byte lost during load.

Function
REQ-020 SHALL implement states IDLE, LOAD, UNPACK, START, RUN, TX, TX_WAIT.
REQ-021 IDLE: rx_rdy latches rx_data into holding register, clears byte/bit counters, enters UNPACK.
REQ-022 UNPACK: 8 cycles, each asserts ram_we=1, ram_d=hold[bit], ram_addr=byte*8+bit; bit counter 0..7.
REQ-023 After bit 7: if byte counter = NUM_BYTES-1 go to START, else increment byte counter and go to LOAD (or directly UNPACK if a pending byte exists).
REQ-024 LOAD: rx_rdy latches byte into holding register and enters UNPACK next cycle.
REQ-025 SHALL provide one-deep pending buffer: rx_rdy during UNPACK stores byte as pending; pending byte consumed at end of current UNPACK with no idle cycle.
REQ-026 rx_rdy during UNPACK with pending already full SHALL drop the byte and set overrun; overrun cleared only by reset or by entering UNPACK from IDLE.
REQ-027 rx_rdy in START, RUN, TX, TX_WAIT SHALL be ignored and SHALL NOT set overrun.
REQ-028 START: core_start=1 for exactly one cycle, next state RUN; core_start first asserts the cycle after the 784th RAM write.
REQ-029 RAM port mux: in IDLE/LOAD/UNPACK ram_addr driven by scheduler; in START/RUN/TX/TX_WAIT ram_addr = core_addr combinationally, ram_we=0.
REQ-030 RUN: on core_done=1 capture core_digit into digit register, go to TX; core_done in any other state ignored.
REQ-031 TX: tx_start=1 one cycle, tx_data = ASCII_BASE + digit (8-bit, zero-extended digit, wrap modulo 256), go TX_WAIT.
REQ-032 tx_data SHALL hold its value until next TX state.
REQ-033 TX_WAIT: on tx_done=1 go IDLE; tx_done elsewhere ignored.
REQ-034 core_done and tx_done have no timeout; scheduler waits indefinitely.
REQ-035 ram_we SHALL be 0 in every state except UNPACK.

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE; ram_we=0, ram_addr=0, ram_d=0, core_start=0, tx_start=0, tx_data=8'h00, digit=4'h0, busy=0, overrun=0, counters and buffers cleared.
REQ-037 Reset mid-LOAD/UNPACK/RUN SHALL discard partial frame; next frame restarts at address 0.

Verification
REQ-038 98 bytes 8'hA5 spaced 10 cycles -> 784 writes, addr 0 gets 1, addr 1 gets 0, addr 783 gets 1; core_start one cycle after last write.
REQ-039 Bytes back-to-back every cycle -> second byte held pending, consumed seamlessly; third within same UNPACK sets overrun=1, 97 bytes written, no core_start.
REQ-040 core_done with core_digit=7 in RUN -> digit=7, tx_start next cycle, tx_data=8'h37; tx_done -> IDLE, busy=0.
REQ-041 core_done pulsed during LOAD, tx_done during RUN -> no state change, no tx_start.
REQ-042 During RUN drive core_addr=10'h2A5 -> ram_addr=10'h2A5, ram_we=0.
REQ-043 rst_n low during UNPACK of byte 50 -> all outputs at reset values; fresh frame writes from address 0 and completes normally.

Source files
------------

// File: rtl/snn_sched.sv
// snn_sched: frame scheduler that unpacks received bytes into the input-unit RAM,
// starts the core, and transmits the classified digit as ASCII.
module snn_sched #(
  parameter int         NUM_BYTES  = 98,
  parameter logic [7:0] ASCII_BASE = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic       ram_d,
  input  logic [9:0] core_addr,
  output logic       core_start,
  input  logic       core_done,
  input  logic [3:0] core_digit,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic [3:0] digit,
  output logic       busy,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, LOAD, UNPACK, START, RUN, TX, TX_WAIT} state_t;
  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d, pend_q, pend_d, tx_data_q, tx_data_d;
  logic       pend_v_q, pend_v_d, overrun_q, overrun_d;
  logic [6:0] byte_q, byte_d;
  logic [2:0] bit_q, bit_d;
  logic [3:0] digit_q, digit_d;
  logic       core_side;
  assign core_side  = state_q inside {START, RUN, TX, TX_WAIT};
  assign ram_we     = state_q == UNPACK;
  assign ram_addr   = core_side ? core_addr : {byte_q, bit_q};
  assign ram_d      = ram_we & hold_q[bit_q];
  assign core_start = state_q == START;
  assign tx_start   = state_q == TX;
  assign busy       = state_q != IDLE;
  assign tx_data    = tx_data_q;
  assign digit      = digit_q;
  assign overrun    = overrun_q;
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    overrun_d = overrun_q;
    byte_d    = byte_q;
    bit_d     = bit_q;
    digit_d   = digit_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (rx_rdy) begin
        hold_d    = rx_data;
        byte_d    = '0;
        bit_d     = '0;
        pend_v_d  = 1'b0;
        overrun_d = 1'b0;
        state_d   = UNPACK;
      end
      LOAD: if (rx_rdy) begin
        hold_d  = rx_data;
        state_d = UNPACK;
      end
      UNPACK: begin
        bit_d = bit_q + 3'd1;
        if (bit_q != 3'd7) begin
          if (rx_rdy && !pend_v_q) begin
            pend_d   = rx_data;
            pend_v_d = 1'b1;
          end
          overrun_d = overrun_q | (rx_rdy & pend_v_q);
        end else if (byte_q == 7'(NUM_BYTES - 1)) begin
          pend_v_d = 1'b0;
          state_d  = START;
        end else begin
          // a byte arriving on the last bit is consumed straight away, freeing the pending slot
          byte_d   = byte_q + 7'd1;
          hold_d   = pend_v_q ? pend_q : rx_data;
          pend_d   = rx_data;
          pend_v_d = pend_v_q & rx_rdy;
          state_d  = (pend_v_q || rx_rdy) ? UNPACK : LOAD;
        end
      end
      START: state_d = RUN;
      RUN: if (core_done) begin
        digit_d   = core_digit;
        tx_data_d = ASCII_BASE + {4'h0, core_digit};
        state_d   = TX;
      end
      TX: state_d = TX_WAIT;
      TX_WAIT: if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      overrun_q <= 1'b0;
      byte_q    <= '0;
      bit_q     <= '0;
      digit_q   <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      overrun_q <= overrun_d;
      byte_q    <= byte_d;
      bit_q     <= bit_d;
      digit_q   <= digit_d;
      tx_data_q <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_snn_sched.sv
// tb_snn_sched: frame-level bench; expected RAM image, write counts and ASCII bytes are derived from the received bytes.
module tb_snn_sched;
  logic       clk = 0, rst_n = 0, rx_rdy = 0, core_done = 0, tx_done = 0;
  logic [7:0] rx_data = 0;
  logic [9:0] core_addr = 0;
  logic [3:0] core_digit = 0;
  logic       ram_we, ram_d, core_start, tx_start, busy, overrun;
  logic [9:0] ram_addr;
  logic [7:0] tx_data;
  logic [3:0] digit;
  snn_sched dut (.clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_d(ram_d), .core_addr(core_addr), .core_start(core_start),
    .core_done(core_done), .core_digit(core_digit), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .digit(digit), .busy(busy), .overrun(overrun));
  always #5 clk = ~clk;
  int   cyc = 0, wr_cnt = 0, last_wr = 0, cs_cnt = 0, cs_cyc = 0, ts_cnt = 0;
  logic mem [1024];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr] = ram_d;
      wr_cnt++;
      last_wr = cyc;
    end
    if (core_start) begin
      cs_cnt++;
      cs_cyc = cyc;
    end
    if (tx_start) ts_cnt++;
  end
  int         n_pass = 0, n_tot = 0;
  logic [7:0] eb [98];
  logic [3:0] prev_d = 0;
  typedef struct {
    int         mode;
    logic [7:0] val;
    int         gmin, gmax;
    logic [3:0] d;
    logic [7:0] exp_tx;
  } vec_t;
  vec_t tbl [4];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tot++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else n_pass++;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_rst;
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_digit", digit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
  endtask
  task automatic send(input logic [7:0] v, input int gap);
    rx_rdy = 1;
    rx_data = v;
    tick;
    rx_rdy = 0;
    repeat (gap - 1) tick;
  endtask
  task automatic run_frame(input int mode, input logic [7:0] val, input int gmin, input int gmax,
                           input logic [3:0] d, input logic [7:0] exp_tx, input int abort_at);
    int wb, cb, tb, k, bad;
    for (int i = 0; i < 98; i++) eb[i] = mode != 0 ? 8'($urandom) : val;
    wb = wr_cnt; cb = cs_cnt; tb = ts_cnt;
    for (int i = 0; i < 98; i++) begin
      if (i == abort_at) begin
        send(eb[i], 4);
        @(negedge clk);
        chk("mid_unpack_we", ram_we, 1);
        #1 rst_n = 0;
        #1 chk_rst;
        @(negedge clk) rst_n = 1;
        prev_d = 0;
        tick;
        return;
      end
      if (i == 3) begin
        send(eb[i], 9);
        core_done = 1; tx_done = 1; core_digit = ~prev_d;
        tick;
        core_done = 0; tx_done = 0;
        @(negedge clk);
        chk("load_ign_busy", busy, 1);
        chk("load_ign_digit", digit, prev_d);
        chk("load_ign_tx", ts_cnt - tb, 0);
      end else send(eb[i], $urandom_range(gmax, gmin));
    end
    k = 0;
    while (cs_cnt == cb && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("core_start_seen", cs_cnt != cb, 1);
    chk("writes", wr_cnt - wb, 784);
    chk("cs_after_last_wr", cs_cyc - last_wr, 1);
    bad = 0;
    for (int a = 0; a < 784; a++) if (mem[a] !== eb[a / 8][a % 8]) bad++;
    chk("image_bits", bad, 0);
    tick; tick;
    chk("cs_one_cycle", cs_cnt - cb, 1);
    core_addr = 10'h2A5; rx_rdy = 1; rx_data = 8'hFF; tx_done = 1;
    tick;
    rx_rdy = 0; tx_done = 0;
    @(negedge clk);
    chk("run_ram_addr", ram_addr, 10'h2A5);
    chk("run_ram_we", ram_we, 0);
    chk("run_rx_no_overrun", overrun, 0);
    chk("run_txdone_ign", busy, 1);
    chk("run_no_tx", ts_cnt - tb, 0);
    core_done = 1; core_digit = d;
    tick;
    core_done = 0;
    @(negedge clk);
    chk("tx_start", tx_start, 1);
    chk("tx_data", tx_data, exp_tx);
    chk("digit", digit, d);
    tick;
    @(negedge clk);
    chk("tx_one_cycle", ts_cnt - tb, 1);
    tx_done = 1;
    tick;
    tx_done = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("tx_data_held", tx_data, exp_tx);
    chk("idle_ram_we", ram_we, 0);
    prev_d = d;
  endtask
  initial begin
    int wb, cb, bad;
    logic [7:0] ob [98];
    logic [3:0] rd;
    tbl[0] = '{0, 8'hA5, 10, 10, 4'd7,  8'h37};
    tbl[1] = '{1, 8'h00, 8,  12, 4'd0,  8'h30};
    tbl[2] = '{0, 8'h3C, 8,  9,  4'd15, 8'h3F};
    tbl[3] = '{1, 8'h00, 9,  11, 4'd9,  8'h39};
    #12;
    chk_rst;
    @(negedge clk) rst_n = 1;
    tick;
    for (int t = 0; t < 4; t++) begin
      run_frame(tbl[t].mode, tbl[t].val, tbl[t].gmin, tbl[t].gmax, tbl[t].d, tbl[t].exp_tx, -1);
      if (t == 0) begin
        chk("a5_addr0", mem[0], 1);
        chk("a5_addr1", mem[1], 0);
        chk("a5_addr783", mem[783], 1);
      end
    end
    for (int r = 0; r < 3; r++) begin
      rd = 4'($urandom);
      run_frame(1, 8'h00, 8, 12, rd, 8'(8'h30 + 32'(rd)), -1);
    end
    for (int i = 0; i < 98; i++) ob[i] = 8'($urandom);
    wb = wr_cnt; cb = cs_cnt;
    rx_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      rx_data = ob[i];
      tick;
    end
    rx_rdy = 0;
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    repeat (16) tick;
    for (int i = 3; i < 98; i++) send(ob[i], 10);
    repeat (20) tick;
    chk("ovr_writes", wr_cnt - wb, 97 * 8);
    chk("ovr_no_cs", cs_cnt - cb, 0);
    chk("ovr_busy", busy, 1);
    chk("ovr_sticky", overrun, 1);
    bad = 0;
    for (int a = 0; a < 97 * 8; a++) if (mem[a] !== ob[a / 8 < 2 ? a / 8 : a / 8 + 1][a % 8]) bad++;
    chk("ovr_image", bad, 0);
    #2 rst_n = 0;
    #1 chk_rst;
    @(negedge clk) rst_n = 1;
    prev_d = 0;
    tick;
    run_frame(1, 8'h00, 10, 10, 4'd0, 8'h30, 50);
    rd = 4'($urandom);
    run_frame(1, 8'h00, 8, 12, rd, 8'(8'h30 + 32'(rd)), -1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
